cart_mem_arb: RTL

CART_MEM_ARB -- requirements
Module: cart_mem_arb

---
 rtl/cart_mem_pkg.sv | 27 ++
 rtl/cart_mem_fifo.sv | 76 +++++++
 rtl/cart_mem_arb.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/cart_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cart_mem_pkg
//  Purpose  : Shared constants and the request-sequencer state encoding for
//             the cartridge memory arbiter (cart_mem_arb, cart_mem_fifo).
//  Revision : 1.0 - initial release
// ============================================================================
package cart_mem_pkg;

    // Default loader/CPU byte-address width and controller address width.
    localparam int c_ADDR_W    = 23;
    localparam int c_MEM_AW    = 23;

    // Default read-completion timeout, in clk cycles counted from ISSUE.
    localparam int c_READ_WAIT = 8;

    // Request sequencer states.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ISSUE   = 3'd1,
        ST_WAIT_LO = 3'd2,
        ST_WAIT_HI = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

endpackage : cart_mem_pkg
`default_nettype wire

// File: rtl/cart_mem_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : cart_mem_fifo
//  Purpose  : Small synchronous FIFO holding loader {addr, data} entries.
//             A push while full is dropped unless a pop happens in the same
//             cycle, in which case both are accepted without loss.
//  Ports    : clk, rst      - clock, asynchronous active-high reset
//             push, wdata   - write strobe and entry
//             pop, rdata    - read strobe and head entry (show-ahead)
//             full, empty   - occupancy flags
//             count         - number of stored entries (0..DEPTH)
//  Revision : 1.0 - initial release
// ============================================================================
module cart_mem_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 31
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int c_PW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_PW-1:0]  r_wptr;
    logic [c_PW-1:0]  r_rptr;
    logic [c_PW:0]    r_count;

    logic             w_pop_ok;
    logic             w_push_ok;

    assign w_pop_ok  = pop && !empty;
    // A full FIFO can still take a byte when the head leaves this cycle.
    assign w_push_ok = push && (!full || w_pop_ok);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push_ok) begin
                r_wptr <= r_wptr + c_PW'(1);
            end
            if (w_pop_ok) begin
                r_rptr <= r_rptr + c_PW'(1);
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + (c_PW + 1)'(1);
                2'b01:   r_count <= r_count - (c_PW + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: occupancy is tracked by the pointers/count.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wptr] <= wdata;
        end
    end

    assign rdata = r_mem[r_rptr];
    assign full  = (r_count == (c_PW + 1)'(DEPTH));
    assign empty = (r_count == '0);
    assign count = r_count;

endmodule : cart_mem_fifo
`default_nettype wire

// File: rtl/cart_mem_arb.sv
`default_nettype none
// ============================================================================
//  Module   : cart_mem_arb
//  Purpose  : Arbitrates a byte loader and a CPU read port onto a single
//             8-bit-mode SDRAM controller request interface. Loader bytes
//             are buffered and have priority over CPU reads.
//  Ports    : clk, init                 - clock, async active-high reset
//             ld_wr/ld_addr/ld_data     - loader byte strobe/address/data
//             ld_wait, ld_ovf           - loader back-pressure, sticky overflow
//             cpu_rd/cpu_addr           - CPU read request (level) / address
//             cpu_dout, cpu_valid       - read byte, one-cycle valid pulse
//             mem_addr/din/wtbt/we/rd   - controller request outputs
//             mem_dout, mem_ready       - controller response inputs
//  Revision : 1.0 - initial release
// ============================================================================
module cart_mem_arb
    import cart_mem_pkg::*;
#(
    parameter int                  ADDR_W     = c_ADDR_W,
    parameter logic [c_MEM_AW-1:0] BASE       = '0,
    parameter int                  READ_WAIT  = c_READ_WAIT,
    parameter int                  FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                init,
    input  logic                ld_wr,
    input  logic [ADDR_W-1:0]   ld_addr,
    input  logic [7:0]          ld_data,
    output logic                ld_wait,
    output logic                ld_ovf,
    input  logic                cpu_rd,
    input  logic [ADDR_W-1:0]   cpu_addr,
    output logic [7:0]          cpu_dout,
    output logic                cpu_valid,
    output logic [22:0]         mem_addr,
    output logic [15:0]         mem_din,
    output logic [1:0]          mem_wtbt,
    output logic                mem_we,
    output logic                mem_rd,
    input  logic [15:0]         mem_dout,
    input  logic                mem_ready
);

    localparam int c_FW  = ADDR_W + 8;
    localparam int c_CW  = $clog2(FIFO_DEPTH);
    localparam int c_RCW = $clog2(READ_WAIT + 1);

    state_t              r_state;
    state_t              w_next;

    logic [c_FW-1:0]     w_head;
    logic [ADDR_W-1:0]   w_head_addr;
    logic [7:0]          w_head_data;
    logic                w_full;
    logic                w_empty;
    logic [c_CW:0]       w_count;
    logic                w_pop;

    logic                w_start_wr;
    logic                w_start_rd;
    logic                w_busy;

    logic [c_MEM_AW-1:0] r_mem_addr;
    logic [15:0]         r_mem_din;
    logic [7:0]          r_cpu_dout;
    logic                r_is_rd;
    logic [c_RCW-1:0]    r_rd_cnt;
    logic                r_lo_seen;
    logic                r_ovf;

    logic                w_unused;

    // ------------------------------------------------------------------
    // Loader write buffer
    // ------------------------------------------------------------------
    cart_mem_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (c_FW)
    ) u_fifo (
        .clk   (clk),
        .rst   (init),
        .push  (ld_wr),
        .wdata ({ld_addr, ld_data}),
        .pop   (w_pop),
        .rdata (w_head),
        .full  (w_full),
        .empty (w_empty),
        .count (w_count)
    );

    assign w_head_addr = w_head[c_FW-1:8];
    assign w_head_data = w_head[7:0];

    // One slot of headroom so a loader reacting a cycle late still fits.
    assign ld_wait = (w_count >= (c_CW + 1)'(FIFO_DEPTH - 1));

    // Overflow only when the byte is really lost (no same-cycle pop).
    always_ff @(posedge clk or posedge init) begin
        if (init) begin
            r_ovf <= 1'b0;
        end else if (ld_wr && w_full && !w_pop) begin
            r_ovf <= 1'b1;
        end
    end

    assign ld_ovf = r_ovf;

    // ------------------------------------------------------------------
    // Request start decode. A loader byte arriving this very cycle also
    // blocks a CPU read, so a same-cycle write is always issued first.
    // ------------------------------------------------------------------
    assign w_start_wr = (r_state == ST_IDLE) && !w_empty;
    assign w_start_rd = (r_state == ST_IDLE) && w_empty && cpu_rd && !ld_wr;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge init) begin
        if (init) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_start_wr || w_start_rd) begin
                    w_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                w_next = ST_WAIT_LO;
            end
            ST_WAIT_LO: begin
                // Controller acknowledges by dropping ready; if it never
                // does within two cycles, move on regardless.
                if (!mem_ready || r_lo_seen) begin
                    w_next = ST_WAIT_HI;
                end
            end
            ST_WAIT_HI: begin
                if (mem_ready ||
                    (r_is_rd && (r_rd_cnt >= c_RCW'(READ_WAIT - 1)))) begin
                    w_next = ST_DONE;
                end
            end
            ST_DONE: begin
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_pop     = 1'b0;
        w_busy    = 1'b0;
        mem_we    = 1'b0;
        mem_rd    = 1'b0;
        cpu_valid = 1'b0;
        w_pop     = w_start_wr;
        w_busy    = (r_state == ST_ISSUE) || (r_state == ST_WAIT_LO) ||
                    (r_state == ST_WAIT_HI);
        // DONE drops the request so the controller sees a fresh edge next time.
        mem_we    = w_busy && !r_is_rd;
        mem_rd    = w_busy && r_is_rd;
        cpu_valid = (r_state == ST_DONE) && r_is_rd;
    end

    // ------------------------------------------------------------------
    // Request datapath: address/data latched once at start so they stay
    // stable for the whole transaction.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge init) begin
        if (init) begin
            r_mem_addr <= '0;
            r_mem_din  <= '0;
            r_is_rd    <= 1'b0;
            r_rd_cnt   <= '0;
            r_lo_seen  <= 1'b0;
            r_cpu_dout <= '0;
        end else begin
            if (w_start_wr) begin
                r_mem_addr <= BASE + c_MEM_AW'(w_head_addr);
                r_mem_din  <= {w_head_data, w_head_data};
                r_is_rd    <= 1'b0;
            end else if (w_start_rd) begin
                r_mem_addr <= BASE + c_MEM_AW'(cpu_addr);
                r_is_rd    <= 1'b1;
            end

            // Cycles elapsed since ISSUE; zero during the ISSUE cycle.
            if (w_start_wr || w_start_rd) begin
                r_rd_cnt <= '0;
            end else if (r_rd_cnt != c_RCW'(READ_WAIT)) begin
                r_rd_cnt <= r_rd_cnt + c_RCW'(1);
            end

            r_lo_seen <= (r_state == ST_WAIT_LO) && mem_ready;

            if (r_is_rd && (r_state == ST_WAIT_HI) && (w_next == ST_DONE)) begin
                r_cpu_dout <= mem_dout[7:0];
            end
        end
    end

    assign mem_addr = r_mem_addr;
    assign mem_din  = r_mem_din;
    assign mem_wtbt = 2'b00;
    assign cpu_dout = r_cpu_dout;

    // Upper controller byte is never used in 8-bit mode.
    assign w_unused = ^mem_dout[15:8];

endmodule : cart_mem_arb
`default_nettype wire
